signed_nibble_counter: RTL and testbench

SIGNED_NIBBLE_COUNTER -- requirements
Module: signed_nibble_counter

---
 rtl/signed_nibble_counter.sv | 122 ++++++++++++
 tb/tb_signed_nibble_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_nibble_counter.sv
// signed_nibble_counter
// Four-bit signed up/down/load counter driven by three raw push-buttons.
// Each button is synchronised, debounced and edge-detected into a single
// press pulse. The count is presented as w (sign) .. z (lsb) for a signed
// 7-segment decoder. ovf flags a wrap (WRAP=1) or a blocked step (WRAP=0).
//
// Handshake: there is no valid/ready interface; buttons are level inputs
// and every accepted press produces exactly one single-cycle pulse that is
// consumed on the same edge it is seen.
module signed_nibble_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          WRAP            = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [3:0] load_val,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       ovf
);

  // The debounced level flips on the edge where the counter would reach
  // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
  localparam logic [15:0] ACCEPT_AT = 16'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;

  logic [2:0]  raw_btn;
  logic [2:0]  sync_a;
  logic [2:0]  sync_b;
  logic [2:0]  deb;
  logic [2:0]  deb_prev;
  logic [15:0] stab_cnt [3];
  logic [2:0]  press;

  logic [3:0]  count;
  logic [3:0]  next_count;
  logic        next_ovf;
  logic        up_step;
  logic        down_step;

  assign raw_btn = {btn_load, btn_down, btn_up};

  // Two-flop synchroniser, stability counters and debounced levels per button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 3; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      sync_a   <= raw_btn;
      sync_b   <= sync_a;
      deb_prev <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == ACCEPT_AT) begin
          deb[i]      <= sync_b[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A press is the cycle right after the debounced level rises; releases are silent.
  assign press     = deb & ~deb_prev;
  assign up_step   = press[BTN_UP] & ~press[BTN_DOWN];
  assign down_step = press[BTN_DOWN] & ~press[BTN_UP];

  // Next count and overflow flag: load beats a single step, which beats hold.
  always_comb begin
    next_count = count;
    next_ovf   = 1'b0;
    if (press[BTN_LOAD]) begin
      next_count = load_val;
    end else if (up_step) begin
      if (count == 4'b0111) begin
        next_ovf   = 1'b1;
        next_count = WRAP ? 4'b1000 : 4'b0111;
      end else begin
        next_count = count + 4'd1;
      end
    end else if (down_step) begin
      if (count == 4'b1000) begin
        next_ovf   = 1'b1;
        next_count = WRAP ? 4'b0111 : 4'b1000;
      end else begin
        next_count = count - 4'd1;
      end
    end
  end

  // Count and ovf registers; reset overrides any pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      ovf   <= next_ovf;
    end
  end

  assign w = count[3];
  assign x = count[2];
  assign y = count[1];
  assign z = count[0];

endmodule

// File: tb/tb_signed_nibble_counter.sv
// tb_signed_nibble_counter
// Two instances share all inputs: one wrapping, one saturating. Expected
// per-cycle outputs of both are pushed to a queue before each directed step
// and popped/compared one entry per clock edge.
module tb_signed_nibble_counter;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_load;
  logic [3:0] load_val;

  logic w_w, x_w, y_w, z_w, ovf_w;
  logic w_s, x_s, y_s, z_s, ovf_s;

  logic [9:0] exp_q [$];
  int         checks;
  int         errors;

  signed_nibble_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b1)) dut_wrap (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .load_val (load_val),
    .w        (w_w),
    .x        (x_w),
    .y        (y_w),
    .z        (z_w),
    .ovf      (ovf_w)
  );

  signed_nibble_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .load_val (load_val),
    .w        (w_s),
    .x        (x_s),
    .y        (y_s),
    .z        (z_s),
    .ovf      (ovf_s)
  );

  // Clock and initial values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n identical expectations {wrap count, wrap ovf, sat count, sat ovf}.
  task automatic expect_n(input int n, input logic [3:0] cw, input logic ow,
                          input logic [3:0] cs, input logic os);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({cw, ow, cs, os});
    end
  endtask

  // Pop one expectation and compare against both instances now.
  task automatic check_now(input string tag);
    logic [9:0] obs;
    logic [9:0] exp_v;
    obs = {w_w, x_w, y_w, z_w, ovf_w, w_s, x_s, y_s, z_s, ovf_s};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: expectation queue empty, observed %b", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed wrap=%b ovf=%b sat=%b ovf=%b, expected wrap=%b ovf=%b sat=%b ovf=%b",
               tag, obs[9:6], obs[5], obs[4:1], obs[0],
               exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  // Run n clock edges, checking one queued expectation after each.
  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_now($sformatf("%s[%0d]", tag, i + 1));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    load_val = 4'b0000;

    // Reset state
    tick();
    tick();
    expect_n(1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    check_now("reset_state");

    // Up held 20 cycles: count 0001 on the 7th edge, then no further change
    reset  = 1'b0;
    btn_up = 1'b1;
    expect_n(6,  4'b0000, 1'b0, 4'b0000, 1'b0);
    expect_n(14, 4'b0001, 1'b0, 4'b0001, 1'b0);
    run_cycles(20, "up_hold");
    btn_up = 1'b0;
    expect_n(10, 4'b0001, 1'b0, 4'b0001, 1'b0);
    run_cycles(10, "up_release");

    // Reset, then a 3-cycle glitch on up is ignored
    reset = 1'b1;
    expect_n(1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(1, "reset_again");
    reset  = 1'b0;
    btn_up = 1'b1;
    expect_n(3, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(3, "glitch_high");
    btn_up = 1'b0;
    expect_n(12, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(12, "glitch_after");

    // Load 0111 then up: wrap goes to 1000, saturate holds; ovf one cycle on both
    load_val = 4'b0111;
    btn_load = 1'b1;
    expect_n(6, 4'b0000, 1'b0, 4'b0000, 1'b0);
    expect_n(2, 4'b0111, 1'b0, 4'b0111, 1'b0);
    run_cycles(8, "load_0111");
    btn_load = 1'b0;
    expect_n(8, 4'b0111, 1'b0, 4'b0111, 1'b0);
    run_cycles(8, "load_0111_rel");
    btn_up = 1'b1;
    expect_n(6, 4'b0111, 1'b0, 4'b0111, 1'b0);
    expect_n(1, 4'b1000, 1'b1, 4'b0111, 1'b1);
    expect_n(1, 4'b1000, 1'b0, 4'b0111, 1'b0);
    run_cycles(8, "up_at_max");
    btn_up = 1'b0;
    expect_n(8, 4'b1000, 1'b0, 4'b0111, 1'b0);
    run_cycles(8, "up_at_max_rel");

    // Load 1000 then down: saturate holds at 1000, wrap goes to 0111
    load_val = 4'b1000;
    btn_load = 1'b1;
    expect_n(6, 4'b1000, 1'b0, 4'b0111, 1'b0);
    expect_n(2, 4'b1000, 1'b0, 4'b1000, 1'b0);
    run_cycles(8, "load_1000");
    btn_load = 1'b0;
    expect_n(8, 4'b1000, 1'b0, 4'b1000, 1'b0);
    run_cycles(8, "load_1000_rel");
    btn_down = 1'b1;
    expect_n(6, 4'b1000, 1'b0, 4'b1000, 1'b0);
    expect_n(1, 4'b0111, 1'b1, 4'b1000, 1'b1);
    expect_n(1, 4'b0111, 1'b0, 4'b1000, 1'b0);
    run_cycles(8, "down_at_min");
    btn_down = 1'b0;
    expect_n(8, 4'b0111, 1'b0, 4'b1000, 1'b0);
    run_cycles(8, "down_at_min_rel");

    // Up and down together: no change
    btn_up   = 1'b1;
    btn_down = 1'b1;
    expect_n(10, 4'b0111, 1'b0, 4'b1000, 1'b0);
    run_cycles(10, "up_down_same");
    btn_up   = 1'b0;
    btn_down = 1'b0;
    expect_n(8, 4'b0111, 1'b0, 4'b1000, 1'b0);
    run_cycles(8, "up_down_rel");

    // Up, down and load together: load wins
    load_val = 4'b1011;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    btn_load = 1'b1;
    expect_n(6, 4'b0111, 1'b0, 4'b1000, 1'b0);
    expect_n(4, 4'b1011, 1'b0, 4'b1011, 1'b0);
    run_cycles(10, "load_wins");
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    expect_n(10, 4'b1011, 1'b0, 4'b1011, 1'b0);
    run_cycles(10, "load_wins_rel");

    // Reset two cycles into a held down press; still held -> new press after reset
    btn_down = 1'b1;
    expect_n(2, 4'b1011, 1'b0, 4'b1011, 1'b0);
    run_cycles(2, "down_pre_reset");
    reset = 1'b1;
    expect_n(2, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(2, "mid_press_reset");
    reset = 1'b0;
    expect_n(6, 4'b0000, 1'b0, 4'b0000, 1'b0);
    expect_n(4, 4'b1111, 1'b0, 4'b1111, 1'b0);
    run_cycles(10, "down_after_reset");
    btn_down = 1'b0;
    expect_n(8, 4'b1111, 1'b0, 4'b1111, 1'b0);
    run_cycles(8, "down_after_reset_rel");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
